// File: rtl/stage_if_mt_pkg.sv
// Shared types for the multithreaded fetch stage: pointer, word, thread id
// and the IF/ID payload record.
package stage_if_mt_pkg;

    localparam int unsigned NUM_THREADS = 4;
    localparam int unsigned THREAD_W    = $clog2(NUM_THREADS);
    localparam int unsigned VPTR_W      = 32;
    localparam int unsigned WORD_W      = 32;

    typedef logic [VPTR_W-1:0]   vptr_t;
    typedef logic [WORD_W-1:0]   word_t;
    typedef logic [THREAD_W-1:0] threadid_t;

    typedef struct packed {
        vptr_t     pc;
        word_t     instr;
        threadid_t tid;
        logic      itlb_miss;
    } id_payload_t;

    // Sequential next-PC; wraps modulo 2^VPTR_W.
    function automatic vptr_t pc_next(input vptr_t pc);
        return pc + VPTR_W'(4);
    endfunction

endpackage

// File: rtl/stage_if_mt_scheduler_rr_skip.sv
// Round-robin arbiter that starts searching just after the last granted index
// and skips requesters that are not eligible this cycle.
module scheduler_rr_skip #(
    parameter int unsigned N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         i_req,
    output logic [N-1:0]         o_grant_c,
    output logic [$clog2(N)-1:0] o_grant_idx_c,
    output logic                 o_valid_c
);

    localparam int unsigned IW = $clog2(N);

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_cand;

    // First requester found walking ptr+1 .. ptr+N (power-of-two N wraps naturally).
    always_comb begin
        o_grant_c     = '0;
        o_grant_idx_c = '0;
        o_valid_c     = 1'b0;
        w_cand        = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            w_cand = r_ptr + IW'(k);
            if (!o_valid_c && i_req[w_cand]) begin
                o_valid_c     = 1'b1;
                o_grant_idx_c = w_cand;
            end
        end
        if (o_valid_c) begin
            o_grant_c[o_grant_idx_c] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= IW'(N - 1);
        end else if (o_valid_c) begin
            r_ptr <= o_grant_idx_c;
        end
    end

endmodule

// File: rtl/stage_if_mt.sv
// Multithreaded instruction fetch: per-thread PC file and wait/fault flags,
// round-robin lookup issue to the I-TLB/I-cache, and the registered IF/ID output.
module stage_if_mt
    import stage_if_mt_pkg::*;
#(
    parameter int unsigned N_THREADS = NUM_THREADS,
    parameter vptr_t       BOOT_PC   = 32'h0000_1000,
    parameter vptr_t       EXC_PC    = 32'h0000_2000
) (
    input  logic                 clk,
    input  logic                 rst,
    output vptr_t                fe_pc,
    output threadid_t            fe_thread,
    output logic                 fe_valid,
    input  logic                 itlb_miss,
    input  logic                 icache_miss,
    input  word_t                icache_data,
    input  logic                 fill_done,
    input  threadid_t            fill_thread,
    input  logic                 redir_en,
    input  threadid_t            redir_thread,
    input  vptr_t                redir_pc,
    input  logic                 exc_en,
    input  threadid_t            exc_thread,
    input  logic [N_THREADS-1:0] be_stalled,
    input  logic                 id_ready,
    output logic                 id_valid,
    output vptr_t                id_pc,
    output word_t                id_instruction,
    output threadid_t            id_thread,
    output logic                 id_itlb_miss,
    output logic [N_THREADS-1:0] thread_waiting
);

    vptr_t                r_pc [N_THREADS];
    logic [N_THREADS-1:0] r_wait;
    logic [N_THREADS-1:0] r_fault;
    id_payload_t          r_id;
    logic                 r_id_valid;

    logic                 w_id_free;
    logic [N_THREADS-1:0] w_req;
    logic [N_THREADS-1:0] w_grant;
    threadid_t            w_sel;
    logic                 w_any;
    logic                 w_discard;
    logic                 w_hit;
    logic                 w_tlb_fault;
    logic                 w_cache_miss;
    logic [N_THREADS-1:0] w_exc_vec;
    logic [N_THREADS-1:0] w_redir_vec;
    logic [N_THREADS-1:0] w_fill_vec;

    // Issue only when the ID slot will be free at the next edge.
    assign w_id_free = !r_id_valid || id_ready;
    assign w_req     = ~r_wait & ~r_fault & ~be_stalled & {N_THREADS{w_id_free & ~rst}};

    scheduler_rr_skip #(
        .N (N_THREADS)
    ) u_sched (
        .clk           (clk),
        .rst           (rst),
        .i_req         (w_req),
        .o_grant_c     (w_grant),
        .o_grant_idx_c (w_sel),
        .o_valid_c     (w_any)
    );

    assign fe_valid  = w_any;
    assign fe_thread = w_sel;
    assign fe_pc     = r_pc[w_sel];

    always_comb begin
        w_exc_vec   = '0;
        w_redir_vec = '0;
        w_fill_vec  = '0;
        for (int unsigned t = 0; t < N_THREADS; t++) begin
            w_exc_vec[t]   = exc_en    && (exc_thread   == threadid_t'(t));
            w_redir_vec[t] = redir_en  && (redir_thread == threadid_t'(t));
            w_fill_vec[t]  = fill_done && (fill_thread  == threadid_t'(t));
        end
    end

    // A lookup racing a redirect of its own thread is dropped without side effects.
    assign w_discard    = w_any && (w_exc_vec[w_sel] || w_redir_vec[w_sel]);
    assign w_tlb_fault  = w_any && !w_discard && itlb_miss;
    assign w_cache_miss = w_any && !w_discard && !itlb_miss && icache_miss;
    assign w_hit        = w_any && !w_discard && !itlb_miss && !icache_miss;

    always_ff @(posedge clk) begin
        for (int unsigned t = 0; t < N_THREADS; t++) begin
            if (rst) begin
                r_pc[t] <= BOOT_PC;
            end else if (w_exc_vec[t]) begin
                r_pc[t] <= EXC_PC;
            end else if (w_redir_vec[t]) begin
                r_pc[t] <= redir_pc;
            end else if (w_hit && w_grant[t]) begin
                r_pc[t] <= pc_next(r_pc[t]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait  <= '0;
            r_fault <= '0;
        end else begin
            for (int unsigned t = 0; t < N_THREADS; t++) begin
                if (w_exc_vec[t] || w_redir_vec[t]) begin
                    r_wait[t]  <= 1'b0;
                    r_fault[t] <= 1'b0;
                end else begin
                    if (w_fill_vec[t]) begin
                        r_wait[t] <= 1'b0;
                    end
                    if (w_cache_miss && w_grant[t]) begin
                        r_wait[t] <= 1'b1;
                    end
                    if (w_tlb_fault && w_grant[t]) begin
                        r_fault[t] <= 1'b1;
                    end
                end
            end
        end
    end

    // IF/ID register: capture on hit or TLB fault, hold under backpressure, drain on ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_valid <= 1'b0;
            r_id       <= '0;
        end else if (w_hit || w_tlb_fault) begin
            r_id_valid <= 1'b1;
            r_id       <= '{pc:        fe_pc,
                            instr:     (w_hit ? icache_data : '0),
                            tid:       w_sel,
                            itlb_miss: w_tlb_fault};
        end else if (id_ready) begin
            r_id_valid <= 1'b0;
        end
    end

    assign id_valid       = r_id_valid;
    assign id_pc          = r_id.pc;
    assign id_instruction = r_id.instr;
    assign id_thread      = r_id.tid;
    assign id_itlb_miss   = r_id.itlb_miss;
    assign thread_waiting = r_wait;

endmodule

// File: tb/tb_stage_if_mt.sv
// Directed bench for stage_if_mt: vector table for steady fetch and stalls,
// hand-written sequences for miss/wake, backpressure, redirects, faults and reset.
module tb_stage_if_mt;
    import stage_if_mt_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    vptr_t       fe_pc;
    threadid_t   fe_thread;
    logic        fe_valid;
    logic        itlb_miss, icache_miss;
    word_t       icache_data;
    logic        fill_done;
    threadid_t   fill_thread;
    logic        redir_en;
    threadid_t   redir_thread;
    vptr_t       redir_pc;
    logic        exc_en;
    threadid_t   exc_thread;
    logic [3:0]  be_stalled;
    logic        id_ready;
    logic        id_valid;
    vptr_t       id_pc;
    word_t       id_instruction;
    threadid_t   id_thread;
    logic        id_itlb_miss;
    logic [3:0]  thread_waiting;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stage_if_mt #(
        .N_THREADS (4),
        .BOOT_PC   (32'h0000_1000),
        .EXC_PC    (32'h0000_2000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fe_pc          (fe_pc),
        .fe_thread      (fe_thread),
        .fe_valid       (fe_valid),
        .itlb_miss      (itlb_miss),
        .icache_miss    (icache_miss),
        .icache_data    (icache_data),
        .fill_done      (fill_done),
        .fill_thread    (fill_thread),
        .redir_en       (redir_en),
        .redir_thread   (redir_thread),
        .redir_pc       (redir_pc),
        .exc_en         (exc_en),
        .exc_thread     (exc_thread),
        .be_stalled     (be_stalled),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instruction (id_instruction),
        .id_thread      (id_thread),
        .id_itlb_miss   (id_itlb_miss),
        .thread_waiting (thread_waiting)
    );

    typedef struct {
        logic       rdy;
        logic [3:0] stall;
        word_t      data;
        logic       e_fev;
        int         e_thr;
        vptr_t      e_pc;
        logic       e_idv;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    task automatic drv(input logic rdy, input logic [3:0] stl);
        id_ready     = rdy;
        be_stalled   = stl;
        itlb_miss    = 1'b0;
        icache_miss  = 1'b0;
        icache_data  = '0;
        fill_done    = 1'b0;
        fill_thread  = '0;
        redir_en     = 1'b0;
        redir_thread = '0;
        redir_pc     = '0;
        exc_en       = 1'b0;
        exc_thread   = '0;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_fe(input string nm, input logic v, input int thr, input logic [31:0] pc);
        chk({nm, "_fe_valid"}, 32'(fe_valid), 32'(v));
        if (v) begin
            chk({nm, "_fe_thread"}, 32'(fe_thread), 32'(thr));
            chk({nm, "_fe_pc"}, fe_pc, pc);
        end
    endtask

    task automatic exp_id(input string nm, input logic v, input int thr, input logic [31:0] pc);
        chk({nm, "_id_valid"}, 32'(id_valid), 32'(v));
        if (v) begin
            chk({nm, "_id_thread"}, 32'(id_thread), 32'(thr));
            chk({nm, "_id_pc"}, id_pc, pc);
        end
    endtask

    task automatic run_tbl(input int first, input int cnt);
        for (int i = first; i < first + cnt; i++) begin
            drv(tbl[i].rdy, tbl[i].stall);
            icache_data = tbl[i].data;
            settle();
            exp_fe($sformatf("tbl%0d", i), tbl[i].e_fev, tbl[i].e_thr, tbl[i].e_pc);
            tick();
            exp_id($sformatf("tbl%0d", i), tbl[i].e_idv, tbl[i].e_thr, tbl[i].e_pc);
            if (tbl[i].e_idv) begin
                chk($sformatf("tbl%0d_instr", i), id_instruction, tbl[i].data);
                chk($sformatf("tbl%0d_itlb", i), 32'(id_itlb_miss), 32'd0);
            end
        end
    endtask

    // Single-cycle hit on the expected thread with all inputs otherwise quiet.
    task automatic hit_step(input string nm, input logic [3:0] stl, input int thr, input logic [31:0] pc);
        drv(1'b1, stl);
        settle();
        exp_fe(nm, 1'b1, thr, pc);
        tick();
    endtask

    initial begin
        // rr order after reset, each thread's second grant at +4
        tbl[0]  = '{1'b1, 4'b0000, 32'hA000_0000, 1'b1, 0, 32'h0000_1000, 1'b1};
        tbl[1]  = '{1'b1, 4'b0000, 32'hA000_0001, 1'b1, 1, 32'h0000_1000, 1'b1};
        tbl[2]  = '{1'b1, 4'b0000, 32'hA000_0002, 1'b1, 2, 32'h0000_1000, 1'b1};
        tbl[3]  = '{1'b1, 4'b0000, 32'hA000_0003, 1'b1, 3, 32'h0000_1000, 1'b1};
        tbl[4]  = '{1'b1, 4'b0000, 32'hA000_0004, 1'b1, 0, 32'h0000_1004, 1'b1};
        tbl[5]  = '{1'b1, 4'b0000, 32'hA000_0005, 1'b1, 1, 32'h0000_1004, 1'b1};
        tbl[6]  = '{1'b1, 4'b0000, 32'hA000_0006, 1'b1, 2, 32'h0000_1004, 1'b1};
        tbl[7]  = '{1'b1, 4'b0000, 32'hA000_0007, 1'b1, 3, 32'h0000_1004, 1'b1};
        // all stalled, then only thread 3 released
        tbl[8]  = '{1'b1, 4'b1111, 32'hB000_0000, 1'b0, 0, 32'h0000_0000, 1'b0};
        tbl[9]  = '{1'b1, 4'b0111, 32'hB000_0001, 1'b1, 3, 32'h0000_100C, 1'b1};
        tbl[10] = '{1'b1, 4'b0111, 32'hB000_0002, 1'b1, 3, 32'h0000_1010, 1'b1};
        tbl[11] = '{1'b1, 4'b0111, 32'hB000_0003, 1'b1, 3, 32'h0000_1014, 1'b1};

        rst = 1'b1;
        drv(1'b1, 4'b0000);
        settle();
        chk("rst_fe_valid", 32'(fe_valid), 32'd0);
        tick();
        tick();
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_id_itlb", 32'(id_itlb_miss), 32'd0);
        chk("rst_id_pc", id_pc, 32'd0);
        chk("rst_id_instr", id_instruction, 32'd0);
        chk("rst_id_thread", 32'(id_thread), 32'd0);
        chk("rst_waiting", 32'(thread_waiting), 32'd0);
        rst = 1'b0;

        run_tbl(0, 8);

        // Mid-run reset overrides a concurrent exception and fill.
        rst = 1'b1;
        drv(1'b1, 4'b0000);
        exc_en = 1'b1; exc_thread = 2'd0;
        fill_done = 1'b1; fill_thread = 2'd1;
        settle();
        chk("rst2_fe_valid", 32'(fe_valid), 32'd0);
        tick();
        rst = 1'b0;
        exp_id("rst2", 1'b0, 0, 0);
        chk("rst2_waiting", 32'(thread_waiting), 32'd0);

        // I-cache miss on thread 1, wake via fill_done, refetch same PC.
        hit_step("m0", 4'b0000, 0, 32'h1000);
        drv(1'b1, 4'b0000);
        icache_miss = 1'b1;
        settle();
        exp_fe("m1", 1'b1, 1, 32'h1000);
        tick();
        chk("m1_waiting", 32'(thread_waiting), 32'b0010);
        exp_id("m1", 1'b0, 0, 0);
        hit_step("m2", 4'b0000, 2, 32'h1000);
        hit_step("m3", 4'b0000, 3, 32'h1000);
        drv(1'b1, 4'b0000);
        fill_done = 1'b1; fill_thread = 2'd1;
        settle();
        exp_fe("m4", 1'b1, 0, 32'h1004);
        tick();
        chk("m4_waiting", 32'(thread_waiting), 32'd0);
        hit_step("m5", 4'b0000, 1, 32'h1000);
        exp_id("m5", 1'b1, 1, 32'h1000);

        // Backpressure: payload held, no issue, nothing lost or repeated.
        hit_step("bp0", 4'b0000, 2, 32'h1004);
        exp_id("bp0", 1'b1, 2, 32'h1004);
        for (int i = 0; i < 3; i++) begin
            drv(1'b0, 4'b0000);
            settle();
            chk($sformatf("bp_hold%0d_fe_valid", i), 32'(fe_valid), 32'd0);
            tick();
            exp_id($sformatf("bp_hold%0d", i), 1'b1, 2, 32'h1004);
        end
        hit_step("bp1", 4'b0000, 3, 32'h1004);
        exp_id("bp1", 1'b1, 3, 32'h1004);
        hit_step("bp2", 4'b0000, 0, 32'h1008);
        hit_step("bp3", 4'b0000, 1, 32'h1004);
        hit_step("bp4", 4'b0000, 2, 32'h1008);

        // Exception beats redirect; the concurrent hit on thread 2 is dropped.
        drv(1'b1, 4'b1011);
        exc_en = 1'b1; exc_thread = 2'd2;
        redir_en = 1'b1; redir_thread = 2'd2; redir_pc = 32'h3000;
        settle();
        exp_fe("exc0", 1'b1, 2, 32'h100C);
        tick();
        exp_id("exc0", 1'b0, 0, 0);
        hit_step("exc1", 4'b1011, 2, 32'h2000);
        exp_id("exc1", 1'b1, 2, 32'h2000);

        // I-TLB fault on thread 0: reported, thread skipped until redirected.
        drv(1'b1, 4'b1110);
        itlb_miss = 1'b1;
        settle();
        exp_fe("tlb0", 1'b1, 0, 32'h100C);
        tick();
        exp_id("tlb0", 1'b1, 0, 32'h100C);
        chk("tlb0_itlb", 32'(id_itlb_miss), 32'd1);
        hit_step("tlb1", 4'b0000, 1, 32'h1008);
        hit_step("tlb2", 4'b0000, 2, 32'h2004);
        hit_step("tlb3", 4'b0000, 3, 32'h1008);
        hit_step("tlb4", 4'b0000, 1, 32'h100C);
        drv(1'b1, 4'b1110);
        settle();
        chk("tlb5_fe_valid", 32'(fe_valid), 32'd0);
        tick();
        drv(1'b1, 4'b1110);
        redir_en = 1'b1; redir_thread = 2'd0; redir_pc = 32'h4000;
        settle();
        chk("tlb6_fe_valid", 32'(fe_valid), 32'd0);
        tick();
        hit_step("tlb7", 4'b1110, 0, 32'h4000);
        exp_id("tlb7", 1'b1, 0, 32'h4000);
        chk("tlb7_itlb", 32'(id_itlb_miss), 32'd0);

        run_tbl(8, 4);

        // PC increment wraps at the top of the address space.
        drv(1'b1, 4'b1110);
        redir_en = 1'b1; redir_thread = 2'd0; redir_pc = 32'hFFFF_FFFC;
        settle();
        exp_fe("wrap0", 1'b1, 0, 32'h4004);
        tick();
        exp_id("wrap0", 1'b0, 0, 0);
        hit_step("wrap1", 4'b1110, 0, 32'hFFFF_FFFC);
        hit_step("wrap2", 4'b1110, 0, 32'h0000_0000);
        exp_id("wrap2", 1'b1, 0, 32'h0000_0000);

        // Reset clears a waiting thread and ignores a concurrent fill.
        drv(1'b1, 4'b1101);
        icache_miss = 1'b1;
        settle();
        exp_fe("rw0", 1'b1, 1, 32'h1010);
        tick();
        chk("rw0_waiting", 32'(thread_waiting), 32'b0010);
        rst = 1'b1;
        drv(1'b1, 4'b0000);
        fill_done = 1'b1; fill_thread = 2'd1;
        settle();
        chk("rw1_fe_valid", 32'(fe_valid), 32'd0);
        tick();
        rst = 1'b0;
        chk("rw1_waiting", 32'(thread_waiting), 32'd0);
        hit_step("rw2", 4'b0000, 0, 32'h1000);
        exp_id("rw2", 1'b1, 0, 32'h1000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
